// File: rtl/timekeeper_param.sv
// ============================================================================
// Module   : timekeeper_param
// Purpose  : Prescaled time-of-day counter with edge/auto-repeat adjust and 12 h view
// Revision : 1.0
// ============================================================================
`default_nettype none

module timekeeper_param #(
  parameter int CLK_HZ     = 32768,
  parameter int REPEAT_DLY = 16384,
  parameter int REPEAT_PER = 4096,
  parameter int PW         = 15
) (
  input  logic       Clk,
  input  logic       reset_n,
  input  logic       run,
  input  logic       mode_12h,
  input  logic       min_inc,
  input  logic       min_dec,
  input  logic       hour_inc,
  input  logic       hour_dec,
  output logic [5:0] seconds,
  output logic [5:0] minutes,
  output logic [5:0] hours,
  output logic [5:0] hours_disp,
  output logic       pm,
  output logic       sec_pulse,
  output logic       day_wrap
);

  localparam logic [PW-1:0] c_PRESC_TOP = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] c_RPT_DLY   = PW'(REPEAT_DLY);
  localparam logic [PW-1:0] c_RPT_PER   = PW'(REPEAT_PER);

  logic [PW-1:0] r_presc;
  logic [PW-1:0] r_rpt_cnt;
  logic          r_rpt_phase;
  logic [3:0]    r_adj_prev;
  logic [5:0]    r_seconds, r_minutes, r_hours;
  logic          r_sec_pulse, r_day_wrap;

  logic [3:0] w_adj, w_rise, w_ev;
  logic       w_one_hot, w_rpt_fire;
  logic       w_min_up, w_min_dn, w_hr_up, w_hr_dn, w_min_adj;
  logic       w_presc_top, w_tick, w_sec_wrap, w_min_wrap, w_hr_wrap;
  logic [5:0] w_sec_nxt, w_min_nxt, w_hr_nxt;
  logic [6:0] w_hr_sum, w_hr_sub;

  assign w_adj     = {min_inc, min_dec, hour_inc, hour_dec};
  assign w_rise    = w_adj & ~r_adj_prev;
  assign w_one_hot = $onehot(w_adj);
  // Delay phase waits REPEAT_DLY cycles from the edge, repeat phase re-fires every REPEAT_PER
  assign w_rpt_fire = w_one_hot &&
                      (r_rpt_phase ? (r_rpt_cnt == c_RPT_PER) : (r_rpt_cnt == c_RPT_DLY));
  assign w_ev      = w_rise | (w_rpt_fire ? w_adj : 4'b0000);

  assign w_min_up  = w_ev[3] & ~w_ev[2];
  assign w_min_dn  = w_ev[2] & ~w_ev[3];
  assign w_hr_up   = w_ev[1] & ~w_ev[0];
  assign w_hr_dn   = w_ev[0] & ~w_ev[1];
  assign w_min_adj = w_min_up | w_min_dn;

  assign w_presc_top = (r_presc == c_PRESC_TOP);
  assign w_tick      = run & w_presc_top & ~w_min_adj;
  assign w_sec_wrap  = w_tick & (r_seconds == 6'd59);
  assign w_min_wrap  = w_sec_wrap & (r_minutes == 6'd59);
  assign w_hr_wrap   = w_min_wrap & (r_hours == 6'd23);

  // Tick carry and hour adjust combine into one mod-24 step (range 0..47)
  assign w_hr_sum = {1'b0, r_hours} + {6'd0, w_min_wrap} + {6'd0, w_hr_up} +
                    (w_hr_dn ? 7'd23 : 7'd0);
  assign w_hr_sub = w_hr_sum - 7'd24;
  assign w_hr_nxt = (w_hr_sum >= 7'd24) ? w_hr_sub[5:0] : w_hr_sum[5:0];

  always_comb begin
    w_sec_nxt = r_seconds;
    if (w_min_adj)
      w_sec_nxt = 6'd0;
    else if (w_tick)
      w_sec_nxt = w_sec_wrap ? 6'd0 : r_seconds + 6'd1;
  end

  always_comb begin
    w_min_nxt = r_minutes;
    if (w_min_up)
      w_min_nxt = (r_minutes == 6'd59) ? 6'd0 : r_minutes + 6'd1;
    else if (w_min_dn)
      w_min_nxt = (r_minutes == 6'd0) ? 6'd59 : r_minutes - 6'd1;
    else if (w_sec_wrap)
      w_min_nxt = (r_minutes == 6'd59) ? 6'd0 : r_minutes + 6'd1;
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc     <= '0;
      r_rpt_cnt   <= '0;
      r_rpt_phase <= 1'b0;
      r_adj_prev  <= 4'b0000;
      r_seconds   <= 6'd0;
      r_minutes   <= 6'd0;
      r_hours     <= 6'd0;
      r_sec_pulse <= 1'b0;
      r_day_wrap  <= 1'b0;
    end else begin
      r_adj_prev  <= w_adj;
      r_seconds   <= w_sec_nxt;
      r_minutes   <= w_min_nxt;
      r_hours     <= w_hr_nxt;
      r_sec_pulse <= w_tick;
      r_day_wrap  <= w_hr_wrap;

      if (!run || w_min_adj || w_presc_top)
        r_presc <= '0;
      else
        r_presc <= r_presc + 1'b1;

      if (!w_one_hot) begin
        r_rpt_cnt   <= '0;
        r_rpt_phase <= 1'b0;
      end else if (w_rpt_fire) begin
        r_rpt_cnt   <= {{(PW-1){1'b0}}, 1'b1};
        r_rpt_phase <= 1'b1;
      end else begin
        r_rpt_cnt   <= r_rpt_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    hours_disp = r_hours;
    if (mode_12h) begin
      if (r_hours == 6'd0)
        hours_disp = 6'd12;
      else if (r_hours > 6'd12)
        hours_disp = r_hours - 6'd12;
    end
  end

  assign pm        = (r_hours >= 6'd12);
  assign seconds   = r_seconds;
  assign minutes   = r_minutes;
  assign hours     = r_hours;
  assign sec_pulse = r_sec_pulse;
  assign day_wrap  = r_day_wrap;

endmodule

`default_nettype wire

// File: tb/tb_timekeeper_param.sv
// ============================================================================
// Module   : tb_timekeeper_param
// Purpose  : Scoreboard bench for timekeeper_param (CLK_HZ=4, DLY=8, PER=2)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_timekeeper_param;

  logic       Clk, reset_n, run, mode_12h;
  logic       min_inc, min_dec, hour_inc, hour_dec;
  logic [5:0] seconds, minutes, hours, hours_disp;
  logic       pm, sec_pulse, day_wrap;

  timekeeper_param #(
    .CLK_HZ(4), .REPEAT_DLY(8), .REPEAT_PER(2), .PW(15)
  ) dut (
    .Clk(Clk), .reset_n(reset_n), .run(run), .mode_12h(mode_12h),
    .min_inc(min_inc), .min_dec(min_dec), .hour_inc(hour_inc), .hour_dec(hour_dec),
    .seconds(seconds), .minutes(minutes), .hours(hours), .hours_disp(hours_disp),
    .pm(pm), .sec_pulse(sec_pulse), .day_wrap(day_wrap)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [5:0] s, m, h;
    logic       dw;
  } pulse_t;

  typedef struct packed {
    logic [5:0] s, m, h, d;
    logic       p, sp, dw;
  } snap_t;

  pulse_t pulse_q[$];
  snap_t  snap_q[$];
  string  snap_name_q[$];
  logic   chk_stb, empty_stb;
  int     n_checks, n_fail;

  // Monitor: pops a pulse expectation on every sec_pulse, a snapshot on request
  always @(negedge Clk) begin
    pulse_t pe;
    snap_t  se, sa;
    string  nm;
    if (sec_pulse) begin
      n_checks++;
      if (pulse_q.size() == 0) begin
        n_fail++;
        $display("FAIL sec_pulse_unexpected: got pulse at %0d:%0d:%0d, required none",
                 hours, minutes, seconds);
      end else begin
        pe = pulse_q.pop_front();
        if ({seconds, minutes, hours, day_wrap} !== pe) begin
          n_fail++;
          $display("FAIL tick_value: got %0d:%0d:%0d dw=%0d, required %0d:%0d:%0d dw=%0d",
                   hours, minutes, seconds, day_wrap, pe.h, pe.m, pe.s, pe.dw);
        end
      end
    end else if (day_wrap) begin
      n_checks++;
      n_fail++;
      $display("FAIL day_wrap_alone: got day_wrap=1 with sec_pulse=0, required 0");
    end
    if (chk_stb && snap_q.size() > 0) begin
      se = snap_q.pop_front();
      nm = snap_name_q.pop_front();
      sa = {seconds, minutes, hours, hours_disp, pm, sec_pulse, day_wrap};
      n_checks++;
      if (sa !== se) begin
        n_fail++;
        $display("FAIL %s: got s=%0d m=%0d h=%0d disp=%0d pm=%0d sp=%0d dw=%0d, required s=%0d m=%0d h=%0d disp=%0d pm=%0d sp=%0d dw=%0d",
                 nm, sa.s, sa.m, sa.h, sa.d, sa.p, sa.sp, sa.dw,
                 se.s, se.m, se.h, se.d, se.p, se.sp, se.dw);
      end
    end
    if (empty_stb) begin
      n_checks++;
      if (pulse_q.size() != 0) begin
        n_fail++;
        $display("FAIL pulse_queue_drained: got %0d outstanding pulses, required 0",
                 pulse_q.size());
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic snap(input string nm, input logic [5:0] s, input logic [5:0] m,
                      input logic [5:0] h, input logic [5:0] d,
                      input logic p, input logic sp, input logic dw);
    snap_q.push_back({s, m, h, d, p, sp, dw});
    snap_name_q.push_back(nm);
    chk_stb = 1'b1;
    @(negedge Clk);
    #1;
    chk_stb = 1'b0;
  endtask

  task automatic check_empty();
    empty_stb = 1'b1;
    @(negedge Clk);
    #1;
    empty_stb = 1'b0;
  endtask

  task automatic push_pulse(input int s, input int m, input int h, input logic dw);
    pulse_q.push_back({6'(s), 6'(m), 6'(h), dw});
  endtask

  task automatic pulse_adj(input int which);
    case (which)
      0: min_inc = 1'b1;
      1: min_dec = 1'b1;
      2: hour_inc = 1'b1;
      default: hour_dec = 1'b1;
    endcase
    step(1);
    min_inc = 1'b0; min_dec = 1'b0; hour_inc = 1'b0; hour_dec = 1'b0;
    step(1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0; n_fail = 0;
    chk_stb = 1'b0; empty_stb = 1'b0;
    reset_n = 1'b0; run = 1'b0; mode_12h = 1'b0;
    min_inc = 1'b0; min_dec = 1'b0; hour_inc = 1'b0; hour_dec = 1'b0;
    step(2);

    // Reset values in both display modes
    mode_12h = 1'b1;
    snap("reset_12h", 0, 0, 0, 12, 0, 0, 0);
    mode_12h = 1'b0;
    snap("reset_24h", 0, 0, 0, 0, 0, 0, 0);

    // 59 ticks from reset
    for (int k = 1; k <= 59; k++) push_pulse(k, 0, 0, 1'b0);
    reset_n = 1'b1;
    run = 1'b1;
    step(238);
    run = 1'b0;
    snap("run_59s", 59, 0, 0, 0, 0, 0, 0);
    check_empty();

    // Preload 23:59:00 then run through the day rollover
    pulse_adj(3);
    pulse_adj(1);
    snap("preload", 0, 59, 23, 23, 1, 0, 0);
    for (int k = 1; k <= 59; k++) push_pulse(k, 59, 23, 1'b0);
    push_pulse(0, 0, 0, 1'b1);
    run = 1'b1;
    step(240);
    run = 1'b0;
    snap("day_wrap_cycle", 0, 0, 0, 0, 0, 1, 1);
    step(1);
    snap("day_wrap_after", 0, 0, 0, 0, 0, 0, 0);
    check_empty();

    // Field wraps without borrow, and 12 h mapping
    pulse_adj(1);
    snap("min_dec_wrap", 0, 59, 0, 0, 0, 0, 0);
    pulse_adj(3);
    snap("hour_dec_wrap", 0, 59, 23, 23, 1, 0, 0);
    mode_12h = 1'b1;
    snap("disp_23_12h", 0, 59, 23, 11, 1, 0, 0);
    for (int k = 0; k < 11; k++) pulse_adj(3);
    snap("disp_12_12h", 0, 59, 12, 12, 1, 0, 0);
    pulse_adj(3);
    snap("disp_11_12h", 0, 59, 11, 11, 0, 0, 0);
    pulse_adj(2);
    pulse_adj(2);
    snap("disp_13_12h", 0, 59, 13, 1, 1, 0, 0);
    mode_12h = 1'b0;

    // Minute adjust coincident with a tick
    do_reset();
    for (int k = 0; k < 5; k++) pulse_adj(0);
    for (int k = 1; k <= 37; k++) push_pulse(k, 5, 0, 1'b0);
    push_pulse(1, 6, 0, 1'b0);
    run = 1'b1;
    step(151);
    snap("at_37s", 37, 5, 0, 0, 0, 0, 0);
    min_inc = 1'b1;
    step(1);
    min_inc = 1'b0;
    snap("min_adj_on_tick", 0, 6, 0, 0, 0, 0, 0);
    step(3);
    snap("before_next_tick", 0, 6, 0, 0, 0, 0, 0);
    step(1);
    run = 1'b0;
    snap("next_tick", 1, 6, 0, 0, 0, 1, 0);
    check_empty();

    // Auto-repeat: events at cycles 0, 8, 10, 12
    do_reset();
    hour_inc = 1'b1;
    step(13);
    hour_inc = 1'b0;
    step(1);
    snap("repeat_13", 0, 0, 4, 4, 0, 0, 0);

    // Second input at cycle 9 stops repeating
    do_reset();
    hour_inc = 1'b1;
    step(9);
    min_inc = 1'b1;
    step(6);
    hour_inc = 1'b0;
    min_inc = 1'b0;
    step(1);
    snap("repeat_abort", 0, 1, 2, 2, 0, 0, 0);

    // Cancelled minute pair at seconds=20
    for (int k = 1; k <= 20; k++) push_pulse(k, 1, 2, 1'b0);
    run = 1'b1;
    step(80);
    run = 1'b0;
    step(1);
    min_inc = 1'b1;
    min_dec = 1'b1;
    step(1);
    min_inc = 1'b0;
    min_dec = 1'b0;
    step(1);
    snap("min_cancel", 20, 1, 2, 2, 0, 0, 0);
    check_empty();

    // Asynchronous reset in the middle of a hold
    hour_inc = 1'b1;
    step(5);
    #2;
    reset_n = 1'b0;
    snap("async_reset", 0, 0, 0, 0, 0, 0, 0);
    hour_inc = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(12);
    snap("no_repeat_after", 0, 0, 0, 0, 0, 0, 0);
    check_empty();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
